// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// result = {remainder, quotient}; validity flags a completed division until the opcode is dropped.
module divider #(
  parameter int unsigned WIDTH  = 16,
  parameter logic [3:0]  DIV_OP = 4'b1001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           mycontrol,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 validity,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned      CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_dvd;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_start;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;

  // One restoring step; the partial remainder stays below the divisor so WIDTH+1 bits suffice.
  assign w_start   = (mycontrol == DIV_OP);
  assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_qbit    = ~w_diff[WIDTH];
  assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_qbit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      validity <= 1'b0;
      result   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          validity <= 1'b0;
          if (w_start) begin
            r_dvd <= dividend;
            r_dvs <= divisor;
            r_rem <= '0;
            r_cnt <= '0;
            if (divisor == '0) begin
              // Divide by zero completes immediately: all-ones quotient, dividend as remainder.
              result   <= {dividend, {WIDTH{1'b1}}};
              validity <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_state <= RUN;
            end
          end
        end

        RUN: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_quo_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            result   <= {w_rem_nxt, w_quo_nxt};
            validity <= 1'b1;
            r_state  <= DONE;
          end
        end

        DONE: begin
          // A held opcode parks here so it cannot retrigger.
          if (!w_start) begin
            validity <= 1'b0;
            r_state  <= IDLE;
          end
        end

        default: begin
          validity <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for divider: latency, divide-by-zero, extremes, hold/reissue,
// operand changes while running and reset mid-operation.
`timescale 1ns/1ps
module tb_divider;

  localparam logic [3:0] DIV_OP = 4'b1001;

  logic        clk;
  logic        rst_n;
  logic [3:0]  mycontrol;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        validity;
  logic [31:0] result;

  int n_checks;
  int n_errors;

  divider #(.WIDTH(16), .DIV_OP(DIV_OP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mycontrol (mycontrol),
    .dividend  (dividend),
    .divisor   (divisor),
    .validity  (validity),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with the divide opcode and let the start edge occur.
  task automatic start_div(input logic [15:0] a, input logic [15:0] b);
    dividend  = a;
    divisor   = b;
    mycontrol = DIV_OP;
    step();
  endtask

  // After the start edge: validity must stay low for 15 edges and rise on the 16th.
  task automatic finish_div(input string tag, input logic [31:0] exp);
    logic early;
    early = 1'b0;
    check({tag, "_busy"}, {31'd0, validity}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      step();
      early = early | validity;
    end
    check({tag, "_early"}, {31'd0, early}, 32'd0);
    step();
    check({tag, "_valid"}, {31'd0, validity}, 32'd1);
    check({tag, "_result"}, result, exp);
  endtask

  // Drop the opcode; validity must fall on the next edge while result holds.
  task automatic drop_op(input string tag, input logic [31:0] held);
    mycontrol = 4'b0000;
    step();
    check({tag, "_drop_valid"}, {31'd0, validity}, 32'd0);
    check({tag, "_drop_hold"}, result, held);
  endtask

  task automatic full_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
    start_div(a, b);
    finish_div(tag, exp);
    drop_op(tag, exp);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    mycontrol = 4'b0000;
    dividend  = 16'd0;
    divisor   = 16'd0;
    step();
    step();
    check("reset_valid", {31'd0, validity}, 32'd0);
    check("reset_result", result, 32'd0);

    // Reset dominates a pending start.
    mycontrol = DIV_OP;
    dividend  = 16'd10;
    divisor   = 16'd0;
    step();
    check("reset_prio_valid", {31'd0, validity}, 32'd0);
    check("reset_prio_result", result, 32'd0);
    mycontrol = 4'b0000;
    rst_n     = 1'b1;
    step();

    // Basic 10/4, then hold the opcode and confirm no restart.
    start_div(16'd10, 16'd4);
    finish_div("basic", 32'h0002_0002);
    dividend = 16'd200;
    divisor  = 16'd3;
    for (int i = 0; i < 20; i++) step();
    check("hold_valid", {31'd0, validity}, 32'd1);
    check("hold_result", result, 32'h0002_0002);
    drop_op("hold", 32'h0002_0002);

    // Non-divide opcodes are no-ops.
    mycontrol = 4'b0110;
    dividend  = 16'd9;
    divisor   = 16'd0;
    step();
    step();
    check("noop_valid", {31'd0, validity}, 32'd0);
    check("noop_result", result, 32'h0002_0002);
    mycontrol = 4'b0000;
    step();

    full_div("reissue", 16'd100, 16'd7, 32'h0002_000E);

    // Divide by zero completes one edge after the start.
    start_div(16'h1234, 16'h0000);
    check("dz_valid", {31'd0, validity}, 32'd1);
    check("dz_result", result, 32'h1234_FFFF);
    drop_op("dz", 32'h1234_FFFF);

    full_div("max_by_1", 16'hFFFF, 16'h0001, 32'h0000_FFFF);
    full_div("5_by_max", 16'd5, 16'hFFFF, 32'h0005_0000);
    full_div("max_by_max", 16'hFFFF, 16'hFFFF, 32'h0000_0001);
    full_div("zero_by_5", 16'd0, 16'd5, 32'h0000_0000);
    full_div("1000_by_33", 16'd1000, 16'd33, 32'h000A_001E);
    full_div("8000_by_ff", 16'h8000, 16'h00FF, 32'h0080_0080);

    // Operand and opcode changes while running are ignored.
    start_div(16'd10, 16'd4);
    for (int i = 0; i < 4; i++) step();
    dividend  = 16'd99;
    divisor   = 16'd0;
    mycontrol = 4'b0011;
    for (int i = 0; i < 11; i++) step();
    check("midchg_early", {31'd0, validity}, 32'd0);
    step();
    check("midchg_valid", {31'd0, validity}, 32'd1);
    check("midchg_result", result, 32'h0002_0002);
    drop_op("midchg", 32'h0002_0002);

    // Reset mid-run aborts with no partial result; a fresh run then completes.
    full_div("pre_rst", 16'd77, 16'd5, 32'h0002_000F);
    start_div(16'd10, 16'd4);
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    step();
    check("midrst_valid", {31'd0, validity}, 32'd0);
    check("midrst_result", result, 32'd0);
    mycontrol = 4'b0000;
    for (int i = 0; i < 20; i++) step();
    check("midrst_stay_valid", {31'd0, validity}, 32'd0);
    rst_n = 1'b1;
    step();
    full_div("post_rst", 16'd10, 16'd4, 32'h0002_0002);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter WIDTH, default 16, operand width; result width is 2*WIDTH.
REQ-002 Parameter DIV_OP, default 4'b1001, mycontrol code that requests a divide.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 mycontrol  input  4  operation code; the divider acts only when mycontrol==DIV_OP.
REQ-007 dividend  input  WIDTH  unsigned dividend.
REQ-008 divisor  input  WIDTH  unsigned divisor.
REQ-009 validity  output  1  high when result holds a completed division.
REQ-010 result  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}, i.e. remainder in the upper half and quotient in the lower half.

Function
REQ-011 The divider SHALL use an FSM with three states: IDLE, RUN and DONE.
REQ-012 IDLE: on a clock edge with mycontrol==DIV_OP, the divider SHALL latch dividend and divisor and clear the iteration counter.
  - Divisor nonzero: SHALL go to RUN.
  - Divisor zero: SHALL go to DONE.
REQ-013 IDLE with mycontrol!=DIV_OP SHALL remain in IDLE; validity=0; result holds its last value.
REQ-014 RUN SHALL perform unsigned restoring shift-subtract division, one quotient bit per cycle, MSB first, for exactly WIDTH cycles.
REQ-015 On the WIDTH-th RUN edge, result SHALL load {remainder, quotient}, validity SHALL become 1, and the FSM SHALL go to DONE.
REQ-016 Latency: start accepted on edge k; validity rises after edge k+WIDTH (16 cycles at default WIDTH).
REQ-017 During RUN, changes on dividend, divisor or mycontrol SHALL be ignored; the latched operands are used.
REQ-018 DONE: validity=1 and result is stable.
  - Stay in DONE while mycontrol==DIV_OP, so a held opcode does not retrigger.
  - mycontrol!=DIV_OP: next edge goes to IDLE and validity drops to 0.
REQ-019 validity SHALL be high for at least one cycle per completed operation.
REQ-020 Divide by zero SHALL give quotient all-ones (16'hFFFF at default), remainder equal to the dividend, and validity after one edge.
REQ-021 Quotient SHALL equal floor(dividend/divisor) and remainder SHALL equal dividend mod divisor, both exact for the full unsigned range.
REQ-022 Every non-IDLE value of mycontrol other than DIV_OP SHALL be a no-op.

Reset
REQ-023 With rst_n==0 at a clock edge: FSM=IDLE, validity=0, result=0, counter and operand registers cleared.
REQ-024 Reset SHALL take priority over all other inputs.
REQ-025 Reset during RUN or DONE SHALL abort the operation; no partial result is ever shown.
REQ-026 Reset SHALL have no asynchronous effect.

Verification
REQ-027 Basic: reset, then mycontrol=4'b1001, dividend=10, divisor=4 -> after 16 cycles validity=1, result=32'h0002_0002.
REQ-028 Divide by zero: dividend=16'h1234, divisor=0, mycontrol=4'b1001 -> after one edge validity=1, result=32'h1234_FFFF.
REQ-029 Extremes:
  - 16'hFFFF/1 -> result=32'h0000_FFFF.
  - 5/16'hFFFF -> result=32'h0005_0000.
REQ-030 Hold and reissue:
  - Keep mycontrol=4'b1001 after done -> validity stays 1 and no restart.
  - Drop mycontrol to 4'b0000 -> validity=0 next cycle.
  - Reissue 100/7 -> result=32'h0002_000E.
REQ-031 Operand change mid-RUN: start 10/4, change dividend to 99 at cycle 5 -> result still 32'h0002_0002.
REQ-032 Reset mid-RUN: assert rst_n=0 at cycle 8 -> validity=0 and result=0; release and a new 10/4 completes normally.
